// File: rtl/fir_stream_sequencer.sv
// fir_stream_sequencer: drives the FIR peripheral register map over the simple bus.
// Define FIR_SEQ_CLR_EN to zero the input ring buffer after coefficient load.
module fir_stream_sequencer #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 32,
   parameter int MAX_TAPS = 61,
   parameter int POLL_LIMIT = 255,
   parameter logic [ADDR_W-1:0] IN_BASE = 14'h0000,
   parameter logic [ADDR_W-1:0] COEF_BASE = 14'h0800,
   parameter logic [ADDR_W-1:0] RES_ADDR = 14'h1000,
   parameter logic [ADDR_W-1:0] DONE_ADDR = 14'h1004,
   parameter logic [ADDR_W-1:0] SIZE_ADDR = 14'h1008
) (
   input  logic              M_AXI_ACLK,
   input  logic              M_AXI_ARESETN,
   input  logic              cfg_start,
   input  logic [6:0]        cfg_taps,
   input  logic [15:0]       coef_tdata,
   input  logic              coef_tvalid,
   output logic              coef_tready,
   input  logic [15:0]       s_tdata,
   input  logic              s_tvalid,
   output logic              s_tready,
   output logic [15:0]       m_tdata,
   output logic              m_tvalid,
   input  logic              m_tready,
   output logic              busy,
   output logic              err,
   output logic [ADDR_W-1:0] wrAddr,
   output logic [DATA_W-1:0] wrData,
   output logic              wr,
   input  logic              wrDone,
   output logic [ADDR_W-1:0] rdAddr,
   output logic              rd,
   input  logic [DATA_W-1:0] rdData,
   input  logic              rdDone
);

   localparam int PW = $clog2(POLL_LIMIT + 1);
   localparam logic [6:0] MAX_T = 7'(MAX_TAPS);
   localparam logic [PW-1:0] PLAST = PW'(POLL_LIMIT - 1);

   typedef enum logic [3:0] {
      IDLE,
      SIZE,
      COEF,
`ifdef FIR_SEQ_CLR_EN
      CLR,
`endif
      RUN,
      SAMP,
      POLL,
      RES,
      OUT
   } state_t;

   state_t state, state_nx;
   logic [6:0] taps, taps_nx;
   logic [6:0] idx, idx_nx;
   logic [6:0] k, k_nx;
   logic [PW-1:0] poll, poll_nx;
   logic pend_wr, pend_wr_nx;
   logic pend_rd, pend_rd_nx;
   logic wr_nx, rd_nx;
   logic [ADDR_W-1:0] wr_addr_nx, rd_addr_nx;
   logic [DATA_W-1:0] wr_data_nx;
   logic [15:0] m_tdata_nx;
   logic m_tvalid_nx, err_nx, busy_nx;
   logic coef_tready_nx, s_tready_nx;
   logic wr_done, rd_done, cfg_ok;

   function automatic logic [ADDR_W-1:0] ofs(input logic [6:0] i);
      return ADDR_W'({i, 2'b00});
   endfunction

   function automatic logic [DATA_W-1:0] sext(input logic [15:0] v);
      return {{(DATA_W-16){v[15]}}, v};
   endfunction

   // Done strobes only count while we actually own a transaction
   assign wr_done = wrDone && pend_wr;
   assign rd_done = rdDone && pend_rd;
   assign cfg_ok = cfg_start && (state == IDLE || state == RUN);

   always_comb begin
      state_nx = state;
      taps_nx = taps;
      idx_nx = idx;
      k_nx = k;
      poll_nx = poll;
      pend_wr_nx = pend_wr;
      pend_rd_nx = pend_rd;
      wr_nx = 1'b0;
      rd_nx = 1'b0;
      wr_addr_nx = wrAddr;
      wr_data_nx = wrData;
      rd_addr_nx = rdAddr;
      m_tdata_nx = m_tdata;
      m_tvalid_nx = m_tvalid;
      err_nx = err;
      unique case (state)
         IDLE: begin
         end
         SIZE: begin
            if (wr_done) begin
               pend_wr_nx = 1'b0;
               idx_nx = 7'd0;
               state_nx = COEF;
            end
         end
         COEF: begin
            if (pend_wr) begin
               if (wrDone) begin
                  pend_wr_nx = 1'b0;
                  if (idx == taps - 7'd1) begin
                     k_nx = 7'd0;
`ifdef FIR_SEQ_CLR_EN
                     idx_nx = 7'd0;
                     wr_nx = 1'b1;
                     wr_addr_nx = IN_BASE;
                     wr_data_nx = '0;
                     pend_wr_nx = 1'b1;
                     state_nx = CLR;
`else
                     state_nx = RUN;
`endif
                  end else begin
                     idx_nx = idx + 7'd1;
                  end
               end
            end else if (coef_tvalid && coef_tready) begin
               wr_nx = 1'b1;
               wr_addr_nx = COEF_BASE + ofs(idx);
               wr_data_nx = sext(coef_tdata);
               pend_wr_nx = 1'b1;
            end
         end
`ifdef FIR_SEQ_CLR_EN
         CLR: begin
            if (wr_done) begin
               pend_wr_nx = 1'b0;
               if (idx == taps - 7'd1) begin
                  state_nx = RUN;
               end else begin
                  idx_nx = idx + 7'd1;
                  wr_nx = 1'b1;
                  wr_addr_nx = IN_BASE + ofs(idx + 7'd1);
                  wr_data_nx = '0;
                  pend_wr_nx = 1'b1;
               end
            end
         end
`endif
         RUN: begin
            if (s_tvalid && s_tready && !cfg_start) begin
               wr_nx = 1'b1;
               wr_addr_nx = IN_BASE + ofs(k);
               wr_data_nx = sext(s_tdata);
               pend_wr_nx = 1'b1;
               state_nx = SAMP;
            end
         end
         SAMP: begin
            if (wr_done) begin
               pend_wr_nx = 1'b0;
               k_nx = (k == taps - 7'd1) ? 7'd0 : k + 7'd1;
               poll_nx = '0;
               rd_nx = 1'b1;
               rd_addr_nx = DONE_ADDR;
               pend_rd_nx = 1'b1;
               state_nx = POLL;
            end
         end
         POLL: begin
            if (rd_done) begin
               pend_rd_nx = 1'b0;
               if (rdData != '0) begin
                  rd_nx = 1'b1;
                  rd_addr_nx = RES_ADDR;
                  pend_rd_nx = 1'b1;
                  state_nx = RES;
               end else if (poll == PLAST) begin
                  // filter never finished: drop this sample
                  poll_nx = poll + PW'(1);
                  err_nx = 1'b1;
                  state_nx = RUN;
               end else begin
                  poll_nx = poll + PW'(1);
                  rd_nx = 1'b1;
                  rd_addr_nx = DONE_ADDR;
                  pend_rd_nx = 1'b1;
               end
            end
         end
         RES: begin
            if (rd_done) begin
               pend_rd_nx = 1'b0;
               m_tdata_nx = rdData[15:0];
               m_tvalid_nx = 1'b1;
               state_nx = OUT;
            end
         end
         OUT: begin
            if (m_tready) begin
               m_tvalid_nx = 1'b0;
               state_nx = RUN;
            end
         end
         default: state_nx = IDLE;
      endcase
      if (cfg_ok) begin
         if (cfg_taps == 7'd0 || cfg_taps > MAX_T) begin
            err_nx = 1'b1;
            state_nx = IDLE;
         end else begin
            err_nx = 1'b0;
            taps_nx = cfg_taps;
            wr_nx = 1'b1;
            wr_addr_nx = SIZE_ADDR;
            wr_data_nx = DATA_W'(cfg_taps);
            pend_wr_nx = 1'b1;
            state_nx = SIZE;
         end
      end
      coef_tready_nx = (state_nx == COEF) && !pend_wr_nx;
      s_tready_nx = (state_nx == RUN);
      busy_nx = (state_nx != IDLE);
   end

   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
         state <= IDLE;
         taps <= '0;
         idx <= '0;
         k <= '0;
         poll <= '0;
         pend_wr <= 1'b0;
         pend_rd <= 1'b0;
         wr <= 1'b0;
         rd <= 1'b0;
         wrAddr <= '0;
         wrData <= '0;
         rdAddr <= '0;
         m_tdata <= '0;
         m_tvalid <= 1'b0;
         err <= 1'b0;
         busy <= 1'b0;
         coef_tready <= 1'b0;
         s_tready <= 1'b0;
      end else begin
         state <= state_nx;
         taps <= taps_nx;
         idx <= idx_nx;
         k <= k_nx;
         poll <= poll_nx;
         pend_wr <= pend_wr_nx;
         pend_rd <= pend_rd_nx;
         wr <= wr_nx;
         rd <= rd_nx;
         wrAddr <= wr_addr_nx;
         wrData <= wr_data_nx;
         rdAddr <= rd_addr_nx;
         m_tdata <= m_tdata_nx;
         m_tvalid <= m_tvalid_nx;
         err <= err_nx;
         busy <= busy_nx;
         coef_tready <= coef_tready_nx;
         s_tready <= s_tready_nx;
      end
   end

endmodule

// File: tb/tb_fir_stream_sequencer.sv
// tb_fir_stream_sequencer: random streams against a bus-slave model and
// an expected transaction list built from the register-map rules.
module tb_fir_stream_sequencer;

   localparam logic [13:0] IN_BASE = 14'h0000;
   localparam logic [13:0] COEF_BASE = 14'h0800;
   localparam logic [13:0] RES_ADDR = 14'h1000;
   localparam logic [13:0] DONE_ADDR = 14'h1004;
   localparam logic [13:0] SIZE_ADDR = 14'h1008;
   localparam int POLLS = 4;

   typedef struct packed {
      logic [13:0] a;
      logic [31:0] d;
   } wr_t;

   logic clk = 1'b0;
   logic rst_n;
   logic cfg_start;
   logic [6:0] cfg_taps;
   logic [15:0] coef_tdata;
   logic coef_tvalid, coef_tready;
   logic [15:0] s_tdata;
   logic s_tvalid, s_tready;
   logic [15:0] m_tdata;
   logic m_tvalid, m_tready;
   logic busy, err;
   logic [13:0] wrAddr, rdAddr;
   logic [31:0] wrData, rdData;
   logic wr, wrDone, rd, rdDone;

   int n_cmp = 0;
   int n_bad = 0;
   wr_t obs_wr[$];
   wr_t exp_wr[$];
   int n_done_rd, n_res_rd;
   int zeros_left;
   bit stuck, samp_phase;
   logic [31:0] res_word;
   bit exp_rd_done, exp_rd_res, exp_mv;
   int taps_m, k_m;
   logic [15:0] coef_arr [0:63];

   always #5 clk = ~clk;

   fir_stream_sequencer #(.POLL_LIMIT(POLLS)) dut (
      .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
      .cfg_start(cfg_start), .cfg_taps(cfg_taps),
      .coef_tdata(coef_tdata), .coef_tvalid(coef_tvalid),
      .coef_tready(coef_tready),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
      .busy(busy), .err(err),
      .wrAddr(wrAddr), .wrData(wrData), .wr(wr), .wrDone(wrDone),
      .rdAddr(rdAddr), .rd(rd), .rdData(rdData), .rdDone(rdDone)
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] sx(input logic [15:0] v);
      logic signed [31:0] r;
      r = $signed(v);
      return r;
   endfunction

   // Bus slave: logs writes, answers reads, checks protocol timing
   initial begin : bus_slave
      logic [13:0] a;
      logic [31:0] d, v;
      bit rs;
      wrDone = 1'b0;
      rdDone = 1'b0;
      rdData = '0;
      forever begin
         @(posedge clk);
         #1;
         wrDone = 1'b0;
         rdDone = 1'b0;
         rdData = $urandom;
         if (!rst_n) begin
            exp_rd_done = 0;
            exp_rd_res = 0;
            exp_mv = 0;
            continue;
         end
         if (exp_rd_done)
            check("rd_done_after_wr", {rd, rdAddr}, {1'b1, DONE_ADDR});
         if (exp_rd_res)
            check("rd_res_after_done", {rd, rdAddr}, {1'b1, RES_ADDR});
         if (exp_mv)
            check("mvalid_after_res", m_tvalid, 1);
         exp_rd_done = 0;
         exp_rd_res = 0;
         exp_mv = 0;
         if (wr && rd)
            check("wr_rd_excl", {wr, rd}, 2'b10);
         if (wr) begin
            a = wrAddr;
            d = wrData;
            rs = 0;
            obs_wr.push_back('{a, d});
            repeat ($urandom_range(1, 3)) begin
               @(posedge clk);
               #1;
               if (!rst_n) rs = 1;
               if (!rs)
                  check("wr_hold", {wr, rd, wrAddr, wrData}, {2'b00, a, d});
            end
            if (!rs) begin
               wrDone = 1'b1;
               if (samp_phase && a < COEF_BASE) exp_rd_done = 1;
            end
         end else if (rd) begin
            a = rdAddr;
            rs = 0;
            if (a == DONE_ADDR) begin
               n_done_rd++;
               if (stuck || zeros_left > 0) v = 32'd0;
               else v = 32'($urandom_range(1, 255)) << $urandom_range(0, 24);
               if (!stuck && zeros_left > 0) zeros_left--;
            end else begin
               n_res_rd++;
               check("rd_addr", a, RES_ADDR);
               v = res_word;
            end
            repeat ($urandom_range(1, 3)) begin
               @(posedge clk);
               #1;
               if (!rst_n) rs = 1;
               if (!rs)
                  check("rd_hold", {wr, rd, rdAddr}, {2'b00, a});
            end
            if (!rs) begin
               rdData = v;
               rdDone = 1'b1;
               if (a == DONE_ADDR && v != 0) exp_rd_res = 1;
               if (a == RES_ADDR) exp_mv = 1;
            end
         end
      end
   end

   task automatic cmp_writes(input string tag);
      wr_t o, e;
      check({tag, "_nwr"}, obs_wr.size(), exp_wr.size());
      while (obs_wr.size() > 0 && exp_wr.size() > 0) begin
         o = obs_wr.pop_front();
         e = exp_wr.pop_front();
         check({tag, "_wr"}, {o.a, o.d}, {e.a, e.d});
      end
      obs_wr.delete();
      exp_wr.delete();
   endtask

   task automatic check_rst(input string tag);
      check({tag, "_ctl"},
            {wr, rd, coef_tready, s_tready, m_tvalid, busy, err}, 0);
      check({tag, "_addr"}, {wrAddr, rdAddr}, 0);
      check({tag, "_wrdata"}, wrData, 0);
      check({tag, "_mtdata"}, m_tdata, 0);
   endtask

   task automatic bad_cfg(input int t, input string tag);
      n_done_rd = 0;
      n_res_rd = 0;
      obs_wr.delete();
      cfg_taps = 7'(t);
      cfg_start = 1'b1;
      @(posedge clk);
      #1;
      cfg_start = 1'b0;
      check({tag, "_err"}, err, 1);
      check({tag, "_idle"}, {busy, s_tready, coef_tready}, 0);
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      check({tag, "_nobus"}, obs_wr.size() + n_done_rd + n_res_rd, 0);
   endtask

   task automatic configure(input int t);
      bit ok;
      cfg_taps = 7'(t);
      cfg_start = 1'b1;
      @(posedge clk);
      #1;
      cfg_start = 1'b0;
      s_tvalid = 1'b0;
      check("cfg_err_clr", err, 0);
      check("cfg_busy", busy, 1);
      taps_m = t;
      k_m = 0;
      exp_wr.push_back('{SIZE_ADDR, 32'(t)});
      for (int i = 0; i < t; i++) begin
         exp_wr.push_back('{COEF_BASE + 14'(4 * i), sx(coef_arr[i])});
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
         coef_tdata = coef_arr[i];
         coef_tvalid = 1'b1;
         ok = 0;
         for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (coef_tready) begin
               ok = 1;
               break;
            end
         end
         @(posedge clk);
         #1;
         coef_tvalid = 1'b0;
         check("coef_accept", ok, 1);
         if (!ok) return;
      end
`ifdef FIR_SEQ_CLR_EN
      for (int i = 0; i < t; i++)
         exp_wr.push_back('{IN_BASE + 14'(4 * i), 32'd0});
`endif
      for (int c = 0; c < 1000; c++) begin
         if (s_tready) break;
         @(posedge clk);
         #1;
      end
      check("cfg_ready", s_tready, 1);
      cmp_writes("cfg");
   endtask

   task automatic send_sample(input logic [15:0] x, input int zeros,
                              input bit stk, input logic [31:0] res,
                              input int hold);
      bit ok, seen_mv;
      zeros_left = zeros;
      stuck = stk;
      res_word = res;
      n_done_rd = 0;
      n_res_rd = 0;
      exp_wr.push_back('{IN_BASE + 14'(4 * k_m), sx(x)});
      s_tdata = x;
      s_tvalid = 1'b1;
      ok = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (s_tready) begin
            ok = 1;
            break;
         end
      end
      samp_phase = 1;
      @(posedge clk);
      #1;
      s_tvalid = 1'b0;
      s_tdata = 16'($urandom);
      check("s_accept", ok, 1);
      check("acc_wr", {wr, wrAddr}, {1'b1, IN_BASE + 14'(4 * k_m)});
      k_m = (k_m + 1) % taps_m;
      if (!stk) begin
         for (int c = 0; c < 200; c++) begin
            if (m_tvalid) break;
            @(posedge clk);
            #1;
         end
         check("m_tvalid", m_tvalid, 1);
         check("m_tdata", m_tdata, res[15:0]);
         check("out_no_sready", s_tready, 0);
         repeat (hold) begin
            @(posedge clk);
            #1;
            check("out_hold", {m_tvalid, s_tready, m_tdata},
                  {2'b10, res[15:0]});
         end
         m_tready = 1'b1;
         @(posedge clk);
         #1;
         m_tready = 1'b0;
         check("out_taken", {m_tvalid, s_tready}, 2'b01);
         check("done_reads", n_done_rd, zeros + 1);
         check("res_reads", n_res_rd, 1);
      end else begin
         seen_mv = 0;
         for (int c = 0; c < 200; c++) begin
            if (m_tvalid) seen_mv = 1;
            if (s_tready) break;
            @(posedge clk);
            #1;
         end
         check("stuck_ready", s_tready, 1);
         check("stuck_no_out", seen_mv, 0);
         check("stuck_polls", n_done_rd, POLLS);
         check("stuck_no_res", n_res_rd, 0);
         check("stuck_err", err, 1);
      end
      samp_phase = 0;
      stuck = 0;
      cmp_writes("samp");
   endtask

   initial begin
      rst_n = 1'b0;
      cfg_start = 1'b0;
      cfg_taps = '0;
      coef_tdata = '0;
      coef_tvalid = 1'b0;
      s_tdata = '0;
      s_tvalid = 1'b0;
      m_tready = 1'b0;
      stuck = 0;
      zeros_left = 0;
      res_word = '0;
      samp_phase = 0;
      taps_m = 1;
      k_m = 0;
      repeat (3) @(posedge clk);
      #1;
      check_rst("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      bad_cfg(0, "taps0");

      coef_arr[0] = 16'd1;
      coef_arr[1] = 16'd2;
      coef_arr[2] = 16'd3;
      configure(3);
      send_sample(16'($urandom), 2, 0, 32'h0001_7FFF, 5);
      for (int i = 0; i < 4; i++)
         send_sample(16'($urandom), $urandom_range(0, 3), 0, $urandom,
                     $urandom_range(0, 3));

      bad_cfg(62, "taps62");

      coef_arr[0] = 16'hFFFE;
      for (int i = 1; i < 4; i++) coef_arr[i] = 16'($urandom);
      configure(4);
      for (int i = 0; i < 6; i++)
         send_sample(16'($urandom), $urandom_range(0, 3), 0, $urandom,
                     $urandom_range(0, 3));
      send_sample(16'($urandom), 0, 1, $urandom, 0);
      send_sample(16'($urandom), 1, 0, $urandom, 1);

      // configuration must win over a sample offered in the same cycle
      for (int i = 0; i < 2; i++) coef_arr[i] = 16'($urandom);
      s_tdata = 16'($urandom);
      s_tvalid = 1'b1;
      configure(2);
      for (int i = 0; i < 4; i++)
         send_sample(16'($urandom), $urandom_range(0, 3), 0, $urandom,
                     $urandom_range(0, 2));

      // reset while polling the done flag
      stuck = 1;
      n_done_rd = 0;
      s_tdata = 16'($urandom);
      s_tvalid = 1'b1;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (s_tready) break;
      end
      @(posedge clk);
      #1;
      s_tvalid = 1'b0;
      for (int c = 0; c < 100; c++) begin
         if (n_done_rd >= 2) break;
         @(posedge clk);
         #1;
      end
      check("poll_reached", n_done_rd >= 2, 1);
      #3;
      rst_n = 1'b0;
      #1;
      check_rst("rst_async");
      @(posedge clk);
      #1;
      check_rst("rst_hold");
      repeat (6) @(posedge clk);
      #1;
      rst_n = 1'b1;
      stuck = 0;
      @(posedge clk);
      #1;
      check_rst("rst_idle");
      obs_wr.delete();
      exp_wr.delete();

      for (int i = 0; i < 61; i++) coef_arr[i] = 16'($urandom);
      configure(61);
      for (int i = 0; i < 3; i++)
         send_sample(16'($urandom), $urandom_range(0, 3), 0, $urandom,
                     $urandom_range(0, 2));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
